// File: rtl/game_round_ctrl_pkg.sv
// Shared encodings for the round sequencer: FSM states, winner codes and score helpers.
package game_round_ctrl_pkg;

  localparam logic [1:0] GAME_IDLE      = 2'b00;
  localparam logic [1:0] GAME_COUNTDOWN = 2'b01;
  localparam logic [1:0] GAME_PLAY      = 2'b10;
  localparam logic [1:0] GAME_OVER      = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  // Single-player rounds always credit P1.
  function automatic logic [1:0] win_code(input logic two, input logic [7:0] s1,
                                          input logic [7:0] s2);
    if (!two)    return WIN_P1;
    if (s1 > s2) return WIN_P1;
    if (s1 < s2) return WIN_P2;
    return WIN_DRAW;
  endfunction

endpackage

// File: rtl/game_round_ctrl_frame_tick_gen.sv
// Turns the vsync level into a single-clock tick on the clock after its rising edge.
module game_round_ctrl_frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_i,
  output logic tick_o
);

  logic vs_q;
  logic tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      vs_q   <= vsync_i;
      tick_q <= vsync_i & ~vs_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: IDLE -> COUNTDOWN -> PLAY -> OVER, owning the HUD timer reset and both scores.
module game_round_ctrl
  import game_round_ctrl_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned COUNT_SEC      = 3,
  parameter int unsigned OVER_FRAMES    = 300,
  parameter int unsigned SCORE_MAX      = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       start_btn,
  input  logic       NoOfPlayers,
  input  logic       p1_hit,
  input  logic       p2_hit,
  input  logic       TimeOut,
  output logic       timer_rst_n,
  output logic       play_en,
  output logic [7:0] Player1Score,
  output logic [7:0] Player2Score,
  output logic       players_lat,
  output logic [1:0] countdown,
  output logic [1:0] winner,
  output logic [1:0] state
);

  localparam int unsigned CD_FRAMES = COUNT_SEC * FRAMES_PER_SEC;
  localparam int unsigned CNT_MAX   = (CD_FRAMES > OVER_FRAMES) ? CD_FRAMES : OVER_FRAMES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned SEC_W     = $clog2(FRAMES_PER_SEC + 1);
  localparam logic [7:0]  SMAX      = 8'(SCORE_MAX);

  logic             btn_s1_q, btn_s2_q, btn_s3_q;
  logic             start_evt;
  logic             frame_tick;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [1:0]       countdown_q, countdown_d;
  logic [1:0]       winner_q, winner_d;
  logic [7:0]       p1_q, p1_d, p2_q, p2_d;
  logic             players_q, players_d;
  logic             timer_rst_n_q, timer_rst_n_d;
  logic             play_en_q, play_en_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      btn_s3_q <= 1'b0;
    end else begin
      btn_s1_q <= start_btn;
      btn_s2_q <= btn_s1_q;
      btn_s3_q <= btn_s2_q;
    end
  end

  assign start_evt = btn_s2_q & ~btn_s3_q;

  game_round_ctrl_frame_tick_gen u_tick (
    .clk     (clk),
    .rst_n   (rst),
    .vsync_i (vsync_in),
    .tick_o  (frame_tick)
  );

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    sec_cnt_d   = sec_cnt_q;
    countdown_d = countdown_q;
    winner_d    = winner_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    players_d   = players_q;

    case (state_q)
      GAME_IDLE: begin
        if (start_evt) begin
          state_d     = GAME_COUNTDOWN;
          p1_d        = '0;
          p2_d        = '0;
          players_d   = NoOfPlayers;
          frame_cnt_d = '0;
          sec_cnt_d   = '0;
          countdown_d = 2'(COUNT_SEC);
        end
      end
      GAME_COUNTDOWN: begin
        if (frame_tick) begin
          if (frame_cnt_q == CNT_W'(CD_FRAMES - 1)) begin
            state_d     = GAME_PLAY;
            frame_cnt_d = '0;
            sec_cnt_d   = '0;
            countdown_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            // Seconds tracked by a separate sub-counter to avoid a divider on frame_cnt.
            if (sec_cnt_q == SEC_W'(FRAMES_PER_SEC - 1)) begin
              sec_cnt_d   = '0;
              countdown_d = countdown_q - 2'd1;
            end else begin
              sec_cnt_d = sec_cnt_q + 1'b1;
            end
          end
        end
      end
      GAME_PLAY: begin
        if (p1_hit)              p1_d = sat_inc(p1_q, SMAX);
        if (p2_hit && players_q) p2_d = sat_inc(p2_q, SMAX);
        if (TimeOut) begin
          state_d     = GAME_OVER;
          frame_cnt_d = '0;
          winner_d    = win_code(players_q, p1_d, p2_d);
        end
      end
      default: begin
        if (start_evt || (frame_tick && frame_cnt_q == CNT_W'(OVER_FRAMES - 1))) begin
          state_d     = GAME_IDLE;
          frame_cnt_d = '0;
          winner_d    = WIN_NONE;
        end else if (frame_tick) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
    endcase

    timer_rst_n_d = (state_d == GAME_PLAY) || (state_d == GAME_OVER);
    play_en_d     = (state_d == GAME_PLAY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= GAME_IDLE;
      frame_cnt_q   <= '0;
      sec_cnt_q     <= '0;
      countdown_q   <= '0;
      winner_q      <= WIN_NONE;
      p1_q          <= '0;
      p2_q          <= '0;
      players_q     <= 1'b0;
      timer_rst_n_q <= 1'b0;
      play_en_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      sec_cnt_q     <= sec_cnt_d;
      countdown_q   <= countdown_d;
      winner_q      <= winner_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      players_q     <= players_d;
      timer_rst_n_q <= timer_rst_n_d;
      play_en_q     <= play_en_d;
    end
  end

  assign state        = state_q;
  assign countdown    = countdown_q;
  assign winner       = winner_q;
  assign Player1Score = p1_q;
  assign Player2Score = p2_q;
  assign players_lat  = players_q;
  assign timer_rst_n  = timer_rst_n_q;
  assign play_en      = play_en_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomized bench for game_round_ctrl with a round-level reference model and literal spot checks.
module tb_game_round_ctrl;

  localparam int FPS  = 60;
  localparam int CSEC = 3;
  localparam int OVF  = 300;
  localparam int SMAX = 99;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vsync_in = 1'b0;
  logic       start_btn = 1'b0;
  logic       NoOfPlayers = 1'b0;
  logic       p1_hit = 1'b0;
  logic       p2_hit = 1'b0;
  logic       TimeOut = 1'b0;
  logic       timer_rst_n, play_en, players_lat;
  logic [7:0] Player1Score, Player2Score;
  logic [1:0] countdown, winner, state;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: round state as integers, frames elapsed in the current state.
  int m_state, m_elapsed, m_p1, m_p2, m_win;
  bit m_pl, m_vprev, m_tick, m_s1, m_s2, m_s3;

  always #5 clk = ~clk;

  game_round_ctrl #(
    .FRAMES_PER_SEC (FPS),
    .COUNT_SEC      (CSEC),
    .OVER_FRAMES    (OVF),
    .SCORE_MAX      (SMAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vsync_in     (vsync_in),
    .start_btn    (start_btn),
    .NoOfPlayers  (NoOfPlayers),
    .p1_hit       (p1_hit),
    .p2_hit       (p2_hit),
    .TimeOut      (TimeOut),
    .timer_rst_n  (timer_rst_n),
    .play_en      (play_en),
    .Player1Score (Player1Score),
    .Player2Score (Player2Score),
    .players_lat  (players_lat),
    .countdown    (countdown),
    .winner       (winner),
    .state        (state)
  );

  initial begin
    forever begin
      repeat ($urandom_range(2, 5)) @(negedge clk);
      vsync_in = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      vsync_in = 1'b0;
    end
  end

  function automatic void model_reset();
    m_state = 0; m_elapsed = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
    m_pl = 0; m_vprev = 0; m_tick = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0;
  endfunction

  function automatic void model_go(int s);
    m_state   = s;
    m_elapsed = 0;
    if (s == 0) m_win = 0;
  endfunction

  function automatic void model_clock();
    bit evt;
    evt = m_s2 && !m_s3;
    case (m_state)
      0: if (evt) begin
        m_p1 = 0; m_p2 = 0; m_pl = NoOfPlayers;
        model_go(1);
      end
      1: if (m_tick) begin
        m_elapsed++;
        if (m_elapsed == CSEC * FPS) model_go(2);
      end
      2: begin
        if (p1_hit && m_p1 < SMAX) m_p1++;
        if (p2_hit && m_pl && m_p2 < SMAX) m_p2++;
        if (TimeOut) begin
          if (!m_pl || m_p1 > m_p2) m_win = 1;
          else if (m_p1 < m_p2)     m_win = 2;
          else                      m_win = 3;
          model_go(3);
        end
      end
      default: begin
        if (evt) model_go(0);
        else if (m_tick) begin
          m_elapsed++;
          if (m_elapsed == OVF) model_go(0);
        end
      end
    endcase
    m_tick  = vsync_in && !m_vprev;
    m_vprev = vsync_in;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = start_btn;
  endfunction

  task automatic compare_cycle();
    logic [1:0] e_st, e_cd, e_win;
    logic [7:0] e_p1, e_p2;
    logic       e_pl, e_trn, e_pe;
    e_st  = m_state[1:0];
    e_cd  = (m_state == 1) ? 2'(CSEC - m_elapsed / FPS) : 2'd0;
    e_win = m_win[1:0];
    e_p1  = m_p1[7:0];
    e_p2  = m_p2[7:0];
    e_pl  = m_pl;
    e_trn = (m_state >= 2);
    e_pe  = (m_state == 2);
    n_cmp++;
    if (state !== e_st || countdown !== e_cd || winner !== e_win || Player1Score !== e_p1 ||
        Player2Score !== e_p2 || players_lat !== e_pl || timer_rst_n !== e_trn || play_en !== e_pe) begin
      n_bad++;
      $display("FAIL cycle t=%0t got st=%0d cd=%0d win=%0d p1=%0d p2=%0d pl=%0d trn=%0d pe=%0d want st=%0d cd=%0d win=%0d p1=%0d p2=%0d pl=%0d trn=%0d pe=%0d",
               $time, state, countdown, winner, Player1Score, Player2Score, players_lat, timer_rst_n, play_en,
               e_st, e_cd, e_win, e_p1, e_p2, e_pl, e_trn, e_pe);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_clock();
    @(negedge clk);
    if (rst) compare_cycle();
  endtask

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_state(int s, int lim);
    int k = 0;
    while (int'(state) != s && k < lim) begin
      step();
      k++;
    end
    chk("wait_state", int'(state), s);
  endtask

  task automatic hit(bit a, bit b);
    p1_hit = a; p2_hit = b;
    step();
    p1_hit = 1'b0; p2_hit = 1'b0;
    step();
  endtask

  task automatic start_round(bit np);
    start_btn = 1'b0;
    repeat (3) step();
    NoOfPlayers = np;
    start_btn = 1'b1;
    repeat (3) step();
    start_btn = 1'b0;
    chk("round_start", int'(state), 1);
    wait_state(2, 2500);
  endtask

  task automatic end_round();
    TimeOut = 1'b1;
    step();
    TimeOut = 1'b0;
    chk("over_state", int'(state), 3);
    chk("over_play_en", int'(play_en), 0);
    chk("over_trn", int'(timer_rst_n), 1);
  endtask

  task automatic leave_over();
    start_btn = 1'b0;
    repeat (3) step();
    start_btn = 1'b1;
    repeat (3) step();
    start_btn = 1'b0;
    chk("over_exit", int'(state), 0);
    chk("over_exit_win", int'(winner), 0);
  endtask

  task automatic play_scores(bit np, int a, int b, int ew);
    int n;
    n = (a > b) ? a : b;
    start_round(np);
    for (int i = 0; i < n; i++) hit(i < a, i < b);
    end_round();
    chk("score_p1", int'(Player1Score), a);
    chk("score_p2", int'(Player2Score), np ? b : 0);
    chk("winner", int'(winner), ew);
  endtask

  task automatic random_round();
    bit np;
    np = 1'($urandom_range(0, 1));
    start_round(np);
    for (int i = 0; i < 300; i++) begin
      p1_hit    = ($urandom_range(0, 3) == 0);
      p2_hit    = ($urandom_range(0, 3) == 0);
      start_btn = (i < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      TimeOut   = (i > 50) && ($urandom_range(0, 49) == 0);
      step();
      if (state != 2'd2) break;
    end
    p1_hit = 1'b0; p2_hit = 1'b0; TimeOut = 1'b0; start_btn = 1'b0;
    if (state == 2'd2) end_round();
    repeat (10) begin
      p1_hit = 1'($urandom_range(0, 1));
      p2_hit = 1'($urandom_range(0, 1));
      step();
    end
    p1_hit = 1'b0; p2_hit = 1'b0;
    leave_over();
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    chk("rst_state", int'(state), 0);
    chk("rst_trn", int'(timer_rst_n), 0);
    chk("rst_p1", int'(Player1Score), 0);
    chk("rst_win", int'(winner), 0);
    rst = 1'b1;
    repeat (2) step();

    // Start latency and countdown into PLAY.
    NoOfPlayers = 1'b1;
    start_btn = 1'b1;
    repeat (2) step();
    chk("cd_entry_early", int'(state), 0);
    step();
    chk("cd_entry", int'(state), 1);
    chk("cd_value", int'(countdown), 3);
    start_btn = 1'b0;
    wait_state(2, 2500);
    chk("play_trn", int'(timer_rst_n), 1);
    chk("play_en", int'(play_en), 1);
    chk("play_cd", int'(countdown), 0);

    // Simultaneous hits and saturation.
    repeat (3) hit(1'b1, 1'b1);
    chk("both_p1", int'(Player1Score), 3);
    chk("both_p2", int'(Player2Score), 3);
    repeat (100) hit(1'b1, 1'b0);
    chk("sat_p1", int'(Player1Score), 99);
    chk("sat_p2", int'(Player2Score), 3);
    repeat (40) begin
      p1_hit = 1'($urandom_range(0, 1));
      p2_hit = 1'($urandom_range(0, 1));
      step();
    end
    p1_hit = 1'b0; p2_hit = 1'b0;
    end_round();
    chk("win_sat", int'(winner), 1);

    // Hits in OVER are ignored, then the OVER timeout returns to IDLE.
    repeat (3) hit(1'b1, 1'b1);
    chk("over_hit_p1", int'(Player1Score), 99);
    wait_state(0, 3500);
    chk("timeout_win", int'(winner), 0);
    chk("held_p1", int'(Player1Score), 99);

    play_scores(1'b0, 4, 6, 1);
    leave_over();
    play_scores(1'b1, 5, 5, 3);
    repeat (50) step();
    leave_over();
    play_scores(1'b1, 7, 4, 1);
    leave_over();
    play_scores(1'b1, 2, 9, 2);
    leave_over();

    // Button bounce in PLAY, then asynchronous reset mid-round.
    start_round(1'b1);
    hit(1'b1, 1'b1);
    repeat (30) begin
      start_btn = 1'($urandom_range(0, 1));
      step();
    end
    start_btn = 1'b0;
    repeat (3) step();
    chk("bounce_state", int'(state), 2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_trn", int'(timer_rst_n), 0);
    chk("arst_pe", int'(play_en), 0);
    chk("arst_state", int'(state), 0);
    chk("arst_p1", int'(Player1Score), 0);
    model_reset();
    step();
    rst = 1'b1;
    step();

    repeat (3) random_round();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
